// File: rtl/mac_rx_pkg.sv
// Shared constants and helpers for the MAC receive packer.
package mac_rx_pkg;

  localparam int unsigned DEFAULT_DATA_BYTES = 4;
  localparam int unsigned DROP_CNT_W         = 16;
  localparam int unsigned MAX_LANES          = 8;

  // Contiguous low-order byte enables for a word holding 'count' bytes (0..8).
  function automatic logic [MAX_LANES-1:0] keep_from_count(input logic [3:0] count);
    logic [MAX_LANES:0] ones;
    ones = ((MAX_LANES + 1)'(1) << count) - (MAX_LANES + 1)'(1);
    return ones[MAX_LANES-1:0];
  endfunction

endpackage

// File: rtl/mac_rx_packer_if.sv
// Byte-wide MAC receive bus and packed AXI-Stream output bus.

interface mac_rx_byte_if;
  logic [7:0] mac_rx_data;
  logic       mac_rx_valid;
  logic       mac_rx_sof;
  logic       mac_rx_eof;
  logic       mac_rx_err;

  modport master (output mac_rx_data, mac_rx_valid, mac_rx_sof, mac_rx_eof, mac_rx_err);
  modport slave  (input  mac_rx_data, mac_rx_valid, mac_rx_sof, mac_rx_eof, mac_rx_err);
endinterface

interface mac_axis_if
  import mac_rx_pkg::*;
#(
  parameter int unsigned DATA_BYTES = DEFAULT_DATA_BYTES
);
  logic [8*DATA_BYTES-1:0] axis_tdata;
  logic [DATA_BYTES-1:0]   axis_tkeep;
  logic                    axis_tvalid;
  logic                    axis_tlast;
  logic                    axis_tuser;
  logic                    axis_tready;

  modport master (output axis_tdata, axis_tkeep, axis_tvalid, axis_tlast, axis_tuser,
                  input  axis_tready);
  modport slave  (input  axis_tdata, axis_tkeep, axis_tvalid, axis_tlast, axis_tuser,
                  output axis_tready);
endinterface

// File: rtl/mac_rx_pkt_fifo.sv
// Store-and-forward word FIFO: writes land behind a tentative pointer and only
// become visible to the reader once the frame is committed.
module mac_rx_pkt_fifo #(
  parameter int unsigned WIDTH = 38,
  parameter int unsigned DEPTH = 512
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             restart,   // discard tentative words before this cycle's write
  input  logic             commit,    // publish tentative words including this cycle's write
  input  logic             rollback,  // discard tentative words after this cycle
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data_c,
  output logic             empty_c,
  output logic             full_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    cmt_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    base_c;
  logic [PW-1:0]    rd_next_c;
  logic [PW-1:0]    wr_next_c;
  logic             rd_ok_c;
  logic             wr_ok_c;

  // Pointer arithmetic; fullness is judged after this cycle's read.
  always_comb begin
    base_c    = restart ? cmt_ptr : wr_ptr;
    empty_c   = (rd_ptr == cmt_ptr);
    rd_ok_c   = rd_en & ~empty_c;
    rd_next_c = rd_ptr + PW'(rd_ok_c);
    full_c    = ((base_c - rd_next_c) == PW'(DEPTH));
    wr_ok_c   = wr_en & ~full_c;
    wr_next_c = base_c + PW'(wr_ok_c);
    rd_data_c = mem[rd_ptr[AW-1:0]];
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (wr_ok_c) begin
      mem[base_c[AW-1:0]] <= wr_data;
    end
  end

  // Tentative, committed and read pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      cmt_ptr <= '0;
      rd_ptr  <= '0;
    end else begin
      wr_ptr <= rollback ? cmt_ptr : wr_next_c;
      if (commit) begin
        cmt_ptr <= wr_next_c;
      end
      rd_ptr <= rd_next_c;
    end
  end

endmodule

// File: rtl/mac_rx_packer.sv
// Packs a byte-wide MAC receive stream into DATA_BYTES-wide AXI-Stream words,
// buffering whole frames so that errored, aborted or oversized frames vanish.
module mac_rx_packer
  import mac_rx_pkg::*;
#(
  parameter int unsigned DATA_BYTES  = DEFAULT_DATA_BYTES,
  parameter int unsigned DEPTH_WORDS = 512,
  parameter bit          DROP_BAD    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  mac_rx_byte_if.slave          rx,
  mac_axis_if.master            axis,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam int unsigned DW = 8 * DATA_BYTES;
  localparam int unsigned BW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam int unsigned EW = DW + DATA_BYTES + 2;
  localparam int unsigned SW = DROP_CNT_W + 1;
  localparam logic [BW-1:0]         LAST_LANE = BW'(DATA_BYTES - 1);
  localparam logic [DROP_CNT_W-1:0] DROP_MAX  = {DROP_CNT_W{1'b1}};

  // Packer state
  logic          frame_open;
  logic [BW-1:0] bcnt;
  logic [DW-1:0] word;
  logic          err_seen;
  logic          ovf;

  // Byte placement
  logic          place_c;
  logic          abort_c;
  logic [BW-1:0] lane_c;
  logic [DW-1:0] word_c;
  logic          err_c;
  logic          ovf_prev_c;
  logic          last_c;
  logic          wr_c;
  logic [MAX_LANES-1:0] keep_all_c;

  // Frame disposition
  logic          ovf_c;
  logic          bad_c;
  logic          eof_drop_c;
  logic          commit_c;
  logic          fifo_wr_c;
  logic [1:0]    drop_inc_c;
  logic [SW-1:0] drop_sum_c;
  logic [EW-1:0] wr_entry_c;

  // FIFO / output stage
  logic          fifo_full_c;
  logic          fifo_empty_c;
  logic [EW-1:0] fifo_rd_data_c;
  logic          load_c;
  logic          rd_en_c;

  // Decide whether this byte joins a frame, which lane it takes and whether a word is due.
  always_comb begin
    place_c    = 1'b0;
    abort_c    = 1'b0;
    lane_c     = bcnt;
    word_c     = word;
    err_c      = err_seen;
    ovf_prev_c = ovf;
    if (rx.mac_rx_valid) begin
      if (rx.mac_rx_sof) begin
        place_c    = 1'b1;
        abort_c    = frame_open;
        lane_c     = '0;
        word_c     = '0;
        err_c      = rx.mac_rx_err;
        ovf_prev_c = 1'b0;
      end else if (frame_open) begin
        place_c = 1'b1;
        err_c   = err_seen | rx.mac_rx_err;
      end
    end
    for (int unsigned i = 0; i < DATA_BYTES; i++) begin
      if (place_c && (lane_c == BW'(i))) begin
        word_c[8*i +: 8] = rx.mac_rx_data;
      end
    end
    last_c     = place_c & rx.mac_rx_eof;
    wr_c       = place_c & (rx.mac_rx_eof | (lane_c == LAST_LANE));
    keep_all_c = keep_from_count(4'(lane_c) + 4'd1);
  end

  // Overflow tracking and the commit / drop decision at end of frame.
  always_comb begin
    ovf_c      = ovf_prev_c | (wr_c & fifo_full_c);
    bad_c      = ovf_c | (DROP_BAD & err_c);
    eof_drop_c = last_c & bad_c;
    commit_c   = last_c & ~bad_c;
    fifo_wr_c  = wr_c & ~ovf_c & ~eof_drop_c;
    drop_inc_c = 2'(abort_c) + 2'(eof_drop_c);
    drop_sum_c = SW'(drop_cnt) + SW'(drop_inc_c);
    wr_entry_c = {last_c & err_c, last_c, keep_all_c[DATA_BYTES-1:0], word_c};
  end

  // Packer registers and saturating drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_open <= 1'b0;
      bcnt       <= '0;
      word       <= '0;
      err_seen   <= 1'b0;
      ovf        <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      if (place_c) begin
        frame_open <= ~last_c;
        bcnt       <= wr_c ? '0 : lane_c + BW'(1);
        word       <= wr_c ? '0 : word_c;
        err_seen   <= err_c & ~last_c;
        ovf        <= ovf_c & ~last_c;
      end
      drop_cnt <= (drop_sum_c > SW'(DROP_MAX)) ? DROP_MAX : drop_sum_c[DROP_CNT_W-1:0];
    end
  end

  mac_rx_pkt_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH_WORDS)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (fifo_wr_c),
    .wr_data   (wr_entry_c),
    .restart   (abort_c),
    .commit    (commit_c),
    .rollback  (eof_drop_c),
    .rd_en     (rd_en_c),
    .rd_data_c (fifo_rd_data_c),
    .empty_c   (fifo_empty_c),
    .full_c    (fifo_full_c)
  );

  assign load_c  = ~axis.axis_tvalid | axis.axis_tready;
  assign rd_en_c = load_c & ~fifo_empty_c;

  // Registered output stage; payload holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      axis.axis_tvalid <= 1'b0;
      axis.axis_tlast  <= 1'b0;
      axis.axis_tuser  <= 1'b0;
      axis.axis_tdata  <= '0;
      axis.axis_tkeep  <= '0;
    end else if (load_c) begin
      axis.axis_tvalid <= ~fifo_empty_c;
      if (!fifo_empty_c) begin
        {axis.axis_tuser, axis.axis_tlast, axis.axis_tkeep, axis.axis_tdata} <= fifo_rd_data_c;
      end
    end
  end

endmodule

// File: tb/tb_mac_rx_packer.sv
// Randomized bench for mac_rx_packer: two instances (drop / forward errored
// frames) share one receive stream and are checked against a frame-level model.
module tb_mac_rx_packer;

  localparam int unsigned DB    = 4;
  localparam int unsigned DW    = 8 * DB;
  localparam int unsigned DEPTH = 16;

  typedef logic [7:0] byte_q_t[$];
  typedef struct packed {
    logic [DW-1:0] data;
    logic [DB-1:0] keep;
    logic          last;
    logic          user;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ready = 1'b1;
  int          ready_mode = 0;
  logic [15:0] drop_a;
  logic [15:0] drop_b;

  always #5 clk = ~clk;

  mac_rx_byte_if rx ();
  mac_axis_if #(.DATA_BYTES(DB)) ax_a ();
  mac_axis_if #(.DATA_BYTES(DB)) ax_b ();

  assign ax_a.axis_tready = ready;
  assign ax_b.axis_tready = ready;

  mac_rx_packer #(.DATA_BYTES(DB), .DEPTH_WORDS(DEPTH), .DROP_BAD(1'b1)) dut_a (
    .clk (clk), .rst (rst), .rx (rx), .axis (ax_a), .drop_cnt (drop_a));

  mac_rx_packer #(.DATA_BYTES(DB), .DEPTH_WORDS(DEPTH), .DROP_BAD(1'b0)) dut_b (
    .clk (clk), .rst (rst), .rx (rx), .axis (ax_b), .drop_cnt (drop_b));

  int    checks = 0;
  int    failures = 0;
  beat_t exp_a[$];
  beat_t exp_b[$];
  beat_t got_a[$];
  int unsigned drops_a = 0;
  int unsigned drops_b = 0;

  // Frame-level reference: what each instance must emit for one frame.
  function automatic void model_frame(input byte_q_t bytes, input bit err, input bit complete);
    int n, nw, cnt;
    beat_t b;
    if (!complete) begin
      drops_a++;
      drops_b++;
      return;
    end
    n  = bytes.size();
    nw = (n + DB - 1) / DB;
    if (nw > DEPTH) begin
      drops_a++;
      drops_b++;
      return;
    end
    if (err) drops_a++;
    for (int w = 0; w < nw; w++) begin
      cnt    = (n - w * DB < DB) ? n - w * DB : DB;
      b      = '0;
      for (int i = 0; i < cnt; i++) b.data[8*i +: 8] = bytes[w*DB + i];
      b.keep = DB'((1 << cnt) - 1);
      b.last = (w == nw - 1);
      if (!err) exp_a.push_back(b);
      b.user = b.last & err;
      exp_b.push_back(b);
    end
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // tready pattern, changed just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       ready = 1'b1;
        1:       ready = ~ready;
        2:       ready = 1'(($urandom_range(3) != 0));
        default: ready = 1'b0;
      endcase
    end
  end

  // Per-cycle output checker for both instances.
  bit    stall_a = 0, stall_b = 0;
  beat_t held_a, held_b;
  always @(negedge clk) begin
    beat_t act, e;
    if (rst) begin
      stall_a = 0;
      stall_b = 0;
    end else begin
      act = {ax_a.axis_tdata, ax_a.axis_tkeep, ax_a.axis_tlast, ax_a.axis_tuser};
      if (stall_a) begin
        checks++;
        if (!ax_a.axis_tvalid || act !== held_a) begin
          failures++;
          $display("FAIL a_stall_hold actual=%h/%0b required=%h/1", act, ax_a.axis_tvalid, held_a);
        end
      end
      if (ax_a.axis_tvalid && ax_a.axis_tready) begin
        checks++;
        if (exp_a.size() == 0) begin
          failures++;
          $display("FAIL a_unexpected_beat actual=%h required=none", act);
        end else begin
          e = exp_a.pop_front();
          if (act !== e) begin
            failures++;
            $display("FAIL a_beat actual=%h required=%h", act, e);
          end
        end
        got_a.push_back(act);
      end
      stall_a = ax_a.axis_tvalid && !ax_a.axis_tready;
      held_a  = act;

      act = {ax_b.axis_tdata, ax_b.axis_tkeep, ax_b.axis_tlast, ax_b.axis_tuser};
      if (stall_b) begin
        checks++;
        if (!ax_b.axis_tvalid || act !== held_b) begin
          failures++;
          $display("FAIL b_stall_hold actual=%h/%0b required=%h/1", act, ax_b.axis_tvalid, held_b);
        end
      end
      if (ax_b.axis_tvalid && ax_b.axis_tready) begin
        checks++;
        if (exp_b.size() == 0) begin
          failures++;
          $display("FAIL b_unexpected_beat actual=%h required=none", act);
        end else begin
          e = exp_b.pop_front();
          if (act !== e) begin
            failures++;
            $display("FAIL b_beat actual=%h required=%h", act, e);
          end
        end
      end
      stall_b = ax_b.axis_tvalid && !ax_b.axis_tready;
      held_b  = act;
    end
  end

  task automatic idle_cycle();
    @(negedge clk);
    rx.mac_rx_valid = 1'b0;
    rx.mac_rx_data  = 8'($urandom);
    rx.mac_rx_sof   = 1'($urandom);
    rx.mac_rx_eof   = 1'($urandom);
    rx.mac_rx_err   = 1'($urandom);
  endtask

  task automatic send_frame(input byte_q_t bytes, input int err_idx, input bit complete,
                            input int gap_pct);
    for (int i = 0; i < bytes.size(); i++) begin
      while (int'($urandom_range(99)) < gap_pct) idle_cycle();
      @(negedge clk);
      rx.mac_rx_valid = 1'b1;
      rx.mac_rx_data  = bytes[i];
      rx.mac_rx_sof   = (i == 0);
      rx.mac_rx_eof   = complete && (i == bytes.size() - 1);
      rx.mac_rx_err   = (i == err_idx);
    end
    idle_cycle();
  endtask

  task automatic send_stray(input byte_q_t bytes);
    for (int i = 0; i < bytes.size(); i++) begin
      @(negedge clk);
      rx.mac_rx_valid = 1'b1;
      rx.mac_rx_data  = bytes[i];
      rx.mac_rx_sof   = 1'b0;
      rx.mac_rx_eof   = 1'($urandom);
      rx.mac_rx_err   = 1'($urandom);
    end
    idle_cycle();
  endtask

  task automatic wait_drain();
    int cyc = 0;
    if (ready_mode == 3) ready_mode = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc >= 3000) begin
      failures++;
      $display("FAIL drain_timeout pending_a=%0d pending_b=%0d required=0", exp_a.size(), exp_b.size());
      exp_a.delete();
      exp_b.delete();
    end
    repeat (6) @(negedge clk);
  endtask

  function automatic byte_q_t seq_bytes(input int n, input int first);
    byte_q_t q;
    for (int i = 0; i < n; i++) q.push_back(8'(first + i));
    return q;
  endfunction

  function automatic byte_q_t rand_bytes(input int n);
    byte_q_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    byte_q_t fb, f1, f2, f3;
    beat_t   ref_log[$];
    bit      pending_open;
    int      n, err_idx;
    bit      complete;

    rx.mac_rx_valid = 1'b0;
    rx.mac_rx_data  = '0;
    rx.mac_rx_sof   = 1'b0;
    rx.mac_rx_eof   = 1'b0;
    rx.mac_rx_err   = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_a_tvalid", 64'(ax_a.axis_tvalid), 0);
    check("rst_a_tlast",  64'(ax_a.axis_tlast), 0);
    check("rst_a_tuser",  64'(ax_a.axis_tuser), 0);
    check("rst_a_tdata",  64'(ax_a.axis_tdata), 0);
    check("rst_a_tkeep",  64'(ax_a.axis_tkeep), 0);
    check("rst_a_drop",   64'(drop_a), 0);
    check("rst_b_tvalid", 64'(ax_b.axis_tvalid), 0);
    check("rst_b_drop",   64'(drop_b), 0);
    rst = 1'b0;
    idle_cycle();

    // Six-byte frame splits into a full word and a two-byte tail
    got_a.delete();
    fb = seq_bytes(6, 1);
    model_frame(fb, 1'b0, 1'b1);
    send_frame(fb, -1, 1'b1, 0);
    wait_drain();
    check("f6_beats", 64'(got_a.size()), 2);
    if (got_a.size() == 2) begin
      check("f6_w0_data", 64'(got_a[0].data), 64'h04030201);
      check("f6_w0_keep", 64'(got_a[0].keep), 64'hF);
      check("f6_w0_last", 64'(got_a[0].last), 0);
      check("f6_w1_data", 64'(got_a[1].data), 64'h00000605);
      check("f6_w1_keep", 64'(got_a[1].keep), 64'h3);
      check("f6_w1_last", 64'(got_a[1].last), 1);
      check("f6_w1_user", 64'(got_a[1].user), 0);
    end

    // One-byte frame and eof-to-tvalid latency
    got_a.delete();
    fb = '{8'hAA};
    model_frame(fb, 1'b0, 1'b1);
    @(negedge clk);
    rx.mac_rx_valid = 1'b1;
    rx.mac_rx_data  = 8'hAA;
    rx.mac_rx_sof   = 1'b1;
    rx.mac_rx_eof   = 1'b1;
    rx.mac_rx_err   = 1'b0;
    idle_cycle();
    check("lat_n1_tvalid", 64'(ax_a.axis_tvalid), 0);
    @(negedge clk);
    check("lat_n2_tvalid", 64'(ax_a.axis_tvalid), 1);
    check("lat_n2_tdata",  64'(ax_a.axis_tdata), 64'hAA);
    wait_drain();
    check("f1_beats", 64'(got_a.size()), 1);
    if (got_a.size() == 1) begin
      check("f1_keep", 64'(got_a[0].keep), 64'h1);
      check("f1_last", 64'(got_a[0].last), 1);
    end

    // 64-byte errored frame followed by a good 8-byte frame
    got_a.delete();
    fb = seq_bytes(64, 8'h40);
    model_frame(fb, 1'b1, 1'b1);
    send_frame(fb, 63, 1'b1, 0);
    f1 = seq_bytes(8, 8'h10);
    model_frame(f1, 1'b0, 1'b1);
    send_frame(f1, -1, 1'b1, 0);
    wait_drain();
    check("err_beats_a", 64'(got_a.size()), 2);
    check("err_drop_a", 64'(drop_a), 1);
    check("err_drop_b", 64'(drop_b), 0);

    // Oversized frame while stalled, then a small frame
    got_a.delete();
    ready_mode = 3;
    repeat (3) @(negedge clk);
    fb = seq_bytes(80, 8'h80);
    model_frame(fb, 1'b0, 1'b1);
    send_frame(fb, -1, 1'b1, 0);
    f1 = seq_bytes(8, 8'h20);
    model_frame(f1, 1'b0, 1'b1);
    send_frame(f1, -1, 1'b1, 0);
    repeat (10) @(negedge clk);
    wait_drain();
    check("ovf_beats_a", 64'(got_a.size()), 2);
    check("ovf_drop_a", 64'(drop_a), 2);
    check("ovf_drop_b", 64'(drop_b), 1);

    // Same three frames with free-flowing and toggling tready
    f1 = rand_bytes(5);
    f2 = rand_bytes(9);
    f3 = rand_bytes(13);
    for (int pass = 0; pass < 2; pass++) begin
      ready_mode = pass;
      got_a.delete();
      model_frame(f1, 1'b0, 1'b1);
      model_frame(f2, 1'b0, 1'b1);
      model_frame(f3, 1'b0, 1'b1);
      send_frame(f1, -1, 1'b1, 0);
      send_frame(f2, -1, 1'b1, 0);
      send_frame(f3, -1, 1'b1, 0);
      wait_drain();
      if (pass == 0) ref_log = got_a;
    end
    check("toggle_beats", 64'(got_a.size()), 64'(ref_log.size()));
    for (int i = 0; i < got_a.size() && i < ref_log.size(); i++)
      check("toggle_beat_eq", 64'(got_a[i].data ^ ref_log[i].data), 0);
    ready_mode = 0;

    // Reset in the middle of a frame
    fb = seq_bytes(20, 8'h60);
    f1 = fb[0:9];
    f2 = fb[10:19];
    send_frame(f1, -1, 1'b0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drops_a = 0;
    drops_b = 0;
    check("mid_rst_tvalid", 64'(ax_a.axis_tvalid), 0);
    check("mid_rst_drop",   64'(drop_a), 0);
    got_a.delete();
    send_stray(f2);
    f3 = seq_bytes(4, 8'hC0);
    model_frame(f3, 1'b0, 1'b1);
    send_frame(f3, -1, 1'b1, 0);
    wait_drain();
    check("post_rst_beats", 64'(got_a.size()), 1);
    if (got_a.size() == 1) begin
      check("post_rst_keep", 64'(got_a[0].keep), 64'hF);
      check("post_rst_last", 64'(got_a[0].last), 1);
      check("post_rst_data", 64'(got_a[0].data), 64'hC3C2C1C0);
    end

    // Randomized frames: gaps, errors, aborts, strays, oversize, stalls
    pending_open = 1'b0;
    for (int f = 0; f < 60; f++) begin
      ready_mode = int'($urandom_range(2));
      n = ($urandom_range(3) == 0) ? int'($urandom_range(1, 8)) : int'($urandom_range(1, 72));
      fb = rand_bytes(n);
      err_idx  = ($urandom_range(5) == 0) ? int'($urandom_range(n - 1)) : -1;
      complete = (f == 59) || ($urandom_range(7) != 0);
      if (!pending_open && $urandom_range(3) == 0) send_stray(rand_bytes(int'($urandom_range(1, 3))));
      model_frame(fb, err_idx >= 0, complete);
      send_frame(fb, err_idx, complete, 25);
      pending_open = !complete;
      if (complete) begin
        wait_drain();
        check("rand_drop_a", 64'(drop_a), 64'(drops_a));
        check("rand_drop_b", 64'(drop_b), 64'(drops_b));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
